// File: rtl/service_pkg.sv
// Shared definitions for the service bay controller and its neighbours.
// TIME_W / COST_W match the widths of the upstream totaliser's totaltime
// and totalcost outputs. The per-service cost/time pairs are the same
// constants the totaliser adds up. The package also holds the bay FSM
// state type and the queued job record.
package service_pkg;

  localparam int TIME_W = 4;
  localparam int COST_W = 6;

  // Individual service cost / time pairs
  localparam int SVC0_COST = 20;
  localparam int SVC0_TIME = 5;
  localparam int SVC1_COST = 30;
  localparam int SVC1_TIME = 7;
  localparam int SVC2_COST = 10;
  localparam int SVC2_TIME = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } bay_state_t;

  // "ticks" carries the job's total time; "time" is reserved in SV.
  typedef struct packed {
    logic [TIME_W-1:0] ticks;
    logic [COST_W-1:0] cost;
  } job_t;

endpackage

// File: rtl/service_bay_controller_if.sv
// Job handshake between the totaliser (master) and the service bay
// controller (slave).
//   job_valid : job offered this cycle
//   job_ready : slave can accept (registered not-full)
//   job_time  : total service time in ticks
//   job_cost  : total service cost
//   job_ovf   : totaliser carry; the job is invalid and gets rejected
interface service_bay_controller_if;
  import service_pkg::*;

  logic              job_valid;
  logic              job_ready;
  logic [TIME_W-1:0] job_time;
  logic [COST_W-1:0] job_cost;
  logic              job_ovf;

  modport master (
    output job_valid,
    output job_time,
    output job_cost,
    output job_ovf,
    input  job_ready
  );

  modport slave (
    input  job_valid,
    input  job_time,
    input  job_cost,
    input  job_ovf,
    output job_ready
  );

endinterface

// File: rtl/service_job_fifo.sv
// Synchronous DEPTH-entry FIFO of job_t records.
//   clk, rst : clock, synchronous active-high reset (pointers/count only)
//   push     : write wr_data at the tail (caller guarantees not full)
//   wr_data  : job to enqueue
//   pop      : drop the head (caller guarantees not empty)
//   rd_data  : current head, combinational read
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : occupancy, 0..DEPTH
module service_job_fifo
  import service_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  job_t             wr_data,
  input  logic             pop,
  output job_t             rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  job_t             mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  // Storage is data only and is never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end
    end
  end

  assign rd_data = mem[rptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/service_bay_controller.sv
// Single-bay service controller. Accepts totalised jobs over the job
// interface, queues them, runs each for its time in tick units, and then
// emits a done/bill pulse. It keeps a saturating revenue total and a
// wrapping completed-job counter. Jobs flagged with the totaliser overflow
// are dropped and answered with a one-cycle reject pulse.
//   clk, rst  : clock, synchronous active-high reset
//   jif       : job handshake (slave side)
//   tick      : time-unit strobe, honoured only in RUN
//   busy      : bay in LOAD or RUN
//   remaining : ticks left on the current job
//   done      : one-cycle completion pulse
//   bill      : cost of the finished job, held between pulses
//   reject    : one-cycle pulse after an overflowed job handshake
//   revenue   : saturating sum of billed costs
//   jobs_done : completed-job count, wraps at 255
//   q_count   : queue occupancy
module service_bay_controller
  import service_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int REV_W = 12,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  service_bay_controller_if.slave   jif,
  input  logic                      tick,
  output logic                      busy,
  output logic [TIME_W-1:0]         remaining,
  output logic                      done,
  output logic [COST_W-1:0]         bill,
  output logic                      reject,
  output logic [REV_W-1:0]          revenue,
  output logic [7:0]                jobs_done,
  output logic [CNT_W-1:0]          q_count
);

  function automatic logic [REV_W-1:0] sat_add(input logic [REV_W-1:0] acc,
                                               input logic [COST_W-1:0] amt);
    logic [REV_W:0] sum;
    sum = {1'b0, acc} + (REV_W+1)'(amt);
    return sum[REV_W] ? '1 : sum[REV_W-1:0];
  endfunction

  bay_state_t       state;
  job_t             new_job;
  job_t             head_job;
  job_t             fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             hs;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_next;
  logic [COST_W-1:0] cost_reg;

  assign hs           = jif.job_valid && jif.job_ready;
  assign push         = hs && !jif.job_ovf && !fifo_full;
  assign pop          = (state == IDLE) && !fifo_empty;
  assign new_job.ticks = jif.job_time;
  assign new_job.cost  = jif.job_cost;

  service_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (new_job),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (q_count)
  );

  // Occupancy after this edge; job_ready is registered from it so it
  // already reads 0 in the cycle the queue becomes full.
  always_comb begin
    count_next = q_count;
    if (push && !pop) begin
      count_next = q_count + 1'b1;
    end else if (!push && pop) begin
      count_next = q_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      jif.job_ready <= 1'b0;
      reject        <= 1'b0;
    end else begin
      jif.job_ready <= (count_next != CNT_W'(DEPTH));
      reject        <= hs && jif.job_ovf;
    end
  end

  // Bay FSM: IDLE pops into head_job, LOAD copies it into the working
  // registers, RUN counts down on tick, DONE is the billing cycle. The
  // done/bill/revenue updates are registered on entry to DONE so they are
  // visible during DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      remaining <= '0;
      done      <= 1'b0;
      bill      <= '0;
      revenue   <= '0;
      jobs_done <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            head_job <= fifo_head;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          remaining <= head_job.ticks;
          cost_reg  <= head_job.cost;
          state     <= RUN;
        end
        RUN: begin
          if (remaining == '0) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            bill      <= cost_reg;
            revenue   <= sat_add(revenue, cost_reg);
            jobs_done <= jobs_done + 8'd1;
            state     <= DONE;
          end else if (tick) begin
            remaining <= remaining - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_service_bay_controller.sv
// Testbench for service_bay_controller: table-driven single-job vectors
// plus hand-written multi-cycle sequences, with a bill scoreboard.
module tb_service_bay_controller;
  import service_pkg::*;

  localparam int DEPTH = 4;
  localparam int REV_W = 12;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int REV_MAX = (1 << REV_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              tick;
  logic              busy;
  logic [TIME_W-1:0] remaining;
  logic              done;
  logic [COST_W-1:0] bill;
  logic              reject;
  logic [REV_W-1:0]  revenue;
  logic [7:0]        jobs_done;
  logic [CNT_W-1:0]  q_count;

  service_bay_controller_if jif();

  service_bay_controller #(.DEPTH(DEPTH), .REV_W(REV_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .jif       (jif),
    .tick      (tick),
    .busy      (busy),
    .remaining (remaining),
    .done      (done),
    .bill      (bill),
    .reject    (reject),
    .revenue   (revenue),
    .jobs_done (jobs_done),
    .q_count   (q_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [COST_W-1:0] exp_bill_q [$];
  int model_rev  = 0;
  int model_jobs = 0;
  bit last_hs;
  bit saw_done;
  bit saw_reject;

  typedef struct {
    logic [TIME_W-1:0] t;
    logic [COST_W-1:0] c;
    logic              ovf;
    int                exp_lat;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: record any handshake before the edge, then sample #1 after
  // it and score done/reject against the model.
  task automatic cyc();
    bit rej_due;
    logic [COST_W-1:0] e;
    last_hs = (jif.job_valid === 1'b1) && (jif.job_ready === 1'b1) && !rst;
    rej_due = last_hs && jif.job_ovf;
    if (last_hs && !jif.job_ovf) exp_bill_q.push_back(jif.job_cost);
    @(posedge clk);
    #1;
    saw_done   = done;
    saw_reject = reject;
    if (reject || rej_due) check("reject", reject, rej_due);
    if (done) begin
      if (exp_bill_q.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        e = exp_bill_q.pop_front();
        check("bill", bill, e);
        model_jobs = (model_jobs + 1) % 256;
        model_rev  = (model_rev + e > REV_MAX) ? REV_MAX : model_rev + e;
        check("revenue", revenue, model_rev);
        check("jobs_done", jobs_done, model_jobs);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_remaining"}, remaining, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_bill"},      bill, 0);
    check({tag, "_reject"},    reject, 0);
    check({tag, "_revenue"},   revenue, 0);
    check({tag, "_jobs_done"}, jobs_done, 0);
    check({tag, "_q_count"},   q_count, 0);
    check({tag, "_ready"},     jif.job_ready, 0);
  endtask

  // Single-cycle reset, check outputs, release and check job_ready rises.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    jif.job_valid = 1'b0;
    cyc();
    exp_bill_q.delete();
    model_rev  = 0;
    model_jobs = 0;
    check_zero(tag);
    rst = 1'b0;
    cyc();
    check({tag, "_ready_after"}, jif.job_ready, 1);
  endtask

  task automatic offer(input logic [TIME_W-1:0] t, input logic [COST_W-1:0] c, input logic ovf);
    bit ok;
    jif.job_valid = 1'b1;
    jif.job_time  = t;
    jif.job_cost  = c;
    jif.job_ovf   = ovf;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      cyc();
      ok = last_hs;
    end
    jif.job_valid = 1'b0;
    jif.job_ovf   = 1'b0;
    check("accept", ok, 1);
  endtask

  // Called right after the accepting edge (that cycle counts as 1).
  task automatic wait_done(output int lat);
    lat = 1;
    while (!saw_done && lat < 100) begin
      cyc();
      lat++;
    end
  endtask

  task automatic wait_idle(input string tag);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 2000 && !idle; i++) begin
      cyc();
      idle = !busy && (q_count == 0) && (exp_bill_q.size() == 0);
    end
    check({tag, "_drain"}, idle, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int exp_rem;
    int k;
    bit ok;

    rst = 1'b1;
    tick = 1'b0;
    jif.job_valid = 1'b0;
    jif.job_time  = '0;
    jif.job_cost  = '0;
    jif.job_ovf   = 1'b0;

    vecs[0] = '{t: 4'd0,               c: 6'd20,              ovf: 1'b0, exp_lat: 4};
    vecs[1] = '{t: TIME_W'(SVC0_TIME), c: COST_W'(SVC0_COST), ovf: 1'b0, exp_lat: 4 + SVC0_TIME};
    vecs[2] = '{t: TIME_W'(SVC1_TIME), c: COST_W'(SVC1_COST), ovf: 1'b0, exp_lat: 4 + SVC1_TIME};
    vecs[3] = '{t: TIME_W'(SVC2_TIME), c: COST_W'(SVC2_COST), ovf: 1'b0, exp_lat: 4 + SVC2_TIME};
    vecs[4] = '{t: 4'd0,               c: 6'd56,              ovf: 1'b1, exp_lat: 1};
    vecs[5] = '{t: 4'd15,              c: 6'd63,              ovf: 1'b0, exp_lat: 19};

    do_reset("rst0");

    // Single jobs, tick held high
    tick = 1'b1;
    for (int v = 0; v < 6; v++) begin
      offer(vecs[v].t, vecs[v].c, vecs[v].ovf);
      if (vecs[v].ovf) begin
        check("ovf_reject_now", saw_reject, 1);
        check("ovf_q_count", q_count, 0);
        for (int i = 0; i < 6; i++) cyc();
        check("ovf_revenue", revenue, model_rev);
      end else begin
        wait_done(lat);
        check("latency", lat, vecs[v].exp_lat);
        cyc();
      end
    end
    wait_idle("table");

    // Time 10, tick every third cycle
    tick = 1'b0;
    offer(4'd10, 6'd40, 1'b0);
    cyc();
    cyc();
    check("rem_load", remaining, 10);
    exp_rem = 10;
    k = 0;
    while (exp_rem != 0 && k < 100) begin
      tick = (k % 3 == 2);
      cyc();
      if (tick) exp_rem--;
      check("rem_step", remaining, exp_rem);
      k++;
    end
    tick = 1'b0;
    cyc();
    check("done_after_ticks", saw_done, 1);
    wait_idle("slow_tick");

    // Queue fill: job 1 runs (stalled, tick=0), four more fill the queue,
    // a sixth waits for a pop; bills must come out in offer order.
    tick = 1'b0;
    offer(4'd15, 6'd1, 1'b0);
    offer(4'd0,  6'd2, 1'b0);
    offer(4'd1,  6'd3, 1'b0);
    offer(4'd2,  6'd4, 1'b0);
    offer(4'd0,  6'd5, 1'b0);
    check("full_q_count", q_count, DEPTH);
    check("full_ready", jif.job_ready, 0);
    jif.job_valid = 1'b1;
    jif.job_time  = 4'd3;
    jif.job_cost  = 6'd6;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("held_off", last_hs, 0);
    end
    tick = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      cyc();
      ok = last_hs;
    end
    jif.job_valid = 1'b0;
    check("sixth_accepted", ok, 1);
    wait_idle("fifo");

    // Revenue saturation from a clean reset
    do_reset("rst1");
    tick = 1'b1;
    for (int i = 0; i < 103; i++) offer(4'd0, 6'd40, 1'b0);
    wait_idle("sat");
    check("sat_revenue", revenue, REV_MAX);
    check("sat_jobs_done", jobs_done, 103);
    offer(4'd0, 6'd1, 1'b0);
    wait_idle("sat2");
    check("sat_revenue_hold", revenue, REV_MAX);
    check("sat_jobs_done2", jobs_done, 104);

    // Reset while running with two jobs queued
    tick = 1'b0;
    offer(4'd8, 6'd9,  1'b0);
    offer(4'd0, 6'd12, 1'b0);
    offer(4'd0, 6'd13, 1'b0);
    check("mid_rem_load", remaining, 8);
    tick = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    check("mid_rem4", remaining, 4);
    check("mid_q_count", q_count, 2);
    check("mid_busy", busy, 1);
    do_reset("rst_mid");
    for (int i = 0; i < 8; i++) cyc();
    check("post_rst_q_count", q_count, 0);
    offer(4'd2, 6'd11, 1'b0);
    wait_done(lat);
    check("post_rst_latency", lat, 6);
    wait_idle("post_rst");

    check("scoreboard_empty", exp_bill_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
